// File: rtl/pe_req_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_req_tracker_pkg
// Brief    : Shared arbitration types and defaults for requester-side wrappers.
// Revision : 1.0 - initial release
// ============================================================================
package pe_req_tracker_pkg;

    localparam int c_STARVE_THRESH_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STARVED = 2'd2
    } pend_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_req_tracker_dec_one_hot.sv
`default_nettype none
// ============================================================================
// Module   : dec_one_hot
// Brief    : Index-to-one-hot decoder; out-of-range indices decode to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dec_one_hot #(
    parameter int WIDTH = 8
) (
    input  logic                     valid,
    input  logic [$clog2(WIDTH)-1:0] index,
    output logic [WIDTH-1:0]         one_hot
);

    localparam int c_IDX_W = $clog2(WIDTH);

    // One extra bit keeps the compare meaningful when WIDTH is a power of two
    logic [c_IDX_W:0] w_index_ext;
    assign w_index_ext = {1'b0, index};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign one_hot[i] = valid && (w_index_ext == (c_IDX_W + 1)'(i));
    end

endmodule
`default_nettype wire

// File: rtl/pe_req_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pe_req_tracker
// Brief    : Pending-request vector, grant retirement and starvation tracking.
// Revision : 1.0 - initial release
// ============================================================================
module pe_req_tracker
    import pe_req_tracker_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STARVE_THRESH = c_STARVE_THRESH_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           set_vec,
    input  logic                       ack_valid,
    input  logic [$clog2(WIDTH)-1:0]   ack_index,
    output logic [WIDTH-1:0]           req_vec,
    output logic [$clog2(WIDTH):0]     pending_count,
    output logic [WIDTH-1:0]           starve_vec,
    output logic                       any_starve,
    output logic                       ack_error
);

    localparam int AGE_WIDTH = $clog2(STARVE_THRESH + 1);
    localparam int CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [AGE_WIDTH-1:0] c_THRESH = AGE_WIDTH'(STARVE_THRESH);

    pend_state_t            r_state   [WIDTH];
    logic [AGE_WIDTH-1:0]   r_age     [WIDTH];
    pend_state_t            w_state_n [WIDTH];
    logic [AGE_WIDTH-1:0]   w_age_n   [WIDTH];

    logic [WIDTH-1:0]       r_req_vec;
    logic [CNT_W-1:0]       r_count;
    logic [WIDTH-1:0]       r_starve;
    logic                   r_any_starve;
    logic                   r_ack_error;

    logic [WIDTH-1:0]       w_ack_oh;
    logic [WIDTH-1:0]       w_ack_hit;
    logic                   w_ack_err;
    logic [WIDTH-1:0]       w_req_n;
    logic [WIDTH-1:0]       w_starve_n;
    logic [CNT_W-1:0]       w_count_n;

    dec_one_hot #(
        .WIDTH (WIDTH)
    ) u_dec (
        .valid   (ack_valid),
        .index   (ack_index),
        .one_hot (w_ack_oh)
    );

    // An ack only takes effect when it lands on a pending bit
    assign w_ack_hit = w_ack_oh & r_req_vec;
    assign w_ack_err = ack_valid && (w_ack_hit == '0);

    always_comb begin
        w_req_n    = '0;
        w_starve_n = '0;
        w_count_n  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_n[i] = r_state[i];
            w_age_n[i]   = r_age[i];
            if (set_vec[i] && (r_state[i] == IDLE || w_ack_hit[i])) begin
                // Fresh request, including one that replaces a just-retired one
                w_state_n[i] = PENDING;
                w_age_n[i]   = '0;
            end else if (w_ack_hit[i]) begin
                w_state_n[i] = IDLE;
                w_age_n[i]   = '0;
            end else if (r_state[i] == PENDING) begin
                w_age_n[i] = r_age[i] + 1'b1;
                if (w_age_n[i] == c_THRESH) begin
                    w_state_n[i] = STARVED;
                end
            end
            w_req_n[i]    = (w_state_n[i] != IDLE);
            w_starve_n[i] = (w_state_n[i] == STARVED);
            w_count_n     = w_count_n + CNT_W'(w_req_n[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= IDLE;
                r_age[i]   <= '0;
            end
            r_req_vec    <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_any_starve <= 1'b0;
            r_ack_error  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_n[i];
                r_age[i]   <= w_age_n[i];
            end
            r_req_vec    <= w_req_n;
            r_count      <= w_count_n;
            r_starve     <= w_starve_n;
            r_any_starve <= |w_starve_n;
            r_ack_error  <= w_ack_err;
        end
    end

    assign req_vec       = r_req_vec;
    assign pending_count = r_count;
    assign starve_vec    = r_starve;
    assign any_starve    = r_any_starve;
    assign ack_error     = r_ack_error;

endmodule
`default_nettype wire
